// File: rtl/hilo_mdu_ctrl.sv
// HI/LO register file and multiply/divide sequencing for the execute stage.
// Multiplies complete in one cycle; divides hand off to an external divider and stall until it returns.
module hilo_mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] mul_result,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        div_start,
   output logic        div_signed,
   output logic        div_annul,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] OP_MULT  = 5'b01111;
   localparam logic [4:0] OP_MULTU = 5'b11111;
   localparam logic [4:0] OP_DIV   = 5'b01110;
   localparam logic [4:0] OP_DIVU  = 5'b11110;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic [31:0] div_a_reg, div_a_next;
   logic [31:0] div_b_reg, div_b_next;
   logic        div_signed_reg, div_signed_next;

   logic        is_mul, is_div;
   logic        start_c, signed_c, annul_c, stall_c;

   assign is_mul = op_valid && (op == OP_MULT || op == OP_MULTU);
   assign is_div = op_valid && (op == OP_DIV  || op == OP_DIVU);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         hi_reg         <= '0;
         lo_reg         <= '0;
         div_a_reg      <= '0;
         div_b_reg      <= '0;
         div_signed_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hi_reg         <= hi_next;
         lo_reg         <= lo_next;
         div_a_reg      <= div_a_next;
         div_b_reg      <= div_b_next;
         div_signed_reg <= div_signed_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      hi_next         = hi_reg;
      lo_next         = lo_reg;
      div_a_next      = div_a_reg;
      div_b_next      = div_b_reg;
      div_signed_next = div_signed_reg;
      start_c         = 1'b0;
      signed_c        = 1'b0;
      annul_c         = 1'b0;
      stall_c         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!flush) begin
               // A multiply outranks a simultaneous move-to on the same cycle.
               if (is_mul) begin
                  {hi_next, lo_next} = mul_result;
               end else begin
                  if (mthi) hi_next = wdata;
                  if (mtlo) lo_next = wdata;
               end
               if (is_div) begin
                  start_c         = 1'b1;
                  signed_c        = (op == OP_DIV);
                  div_signed_next = (op == OP_DIV);
                  div_a_next      = a;
                  div_b_next      = b;
                  stall_c         = 1'b1;
                  state_next      = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            signed_c = div_signed_reg;
            // A flush kills the divide even if the result lands this same cycle.
            if (flush) begin
               annul_c    = 1'b1;
               state_next = IDLE;
            end else begin
               stall_c = 1'b1;
               if (div_ready) begin
                  {hi_next, lo_next} = div_result;
                  state_next         = DIV_DONE;
               end
            end
         end
         DIV_DONE: begin
            // One stall-free cycle lets the held divide retire without restarting.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Gate combinational controls so they drop the moment reset asserts.
   assign div_start  = rst & start_c;
   assign div_signed = rst & signed_c;
   assign div_annul  = rst & annul_c;
   assign stall      = rst & stall_c;
   assign div_a      = div_a_reg;
   assign div_b      = div_b_reg;
   assign hi         = hi_reg;
   assign lo         = lo_reg;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: inputs change on the falling edge, outputs are checked
// shortly after it or on the following falling edge.
module tb_hilo_mdu_ctrl;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [4:0]  op;
   logic [31:0] a, b;
   logic [63:0] mul_result;
   logic        mthi, mtlo;
   logic [31:0] wdata;
   logic        flush;
   logic        div_start, div_signed, div_annul;
   logic [31:0] div_a, div_b;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stall;
   logic [31:0] hi, lo;

   int n_cmp;
   int n_bad;

   localparam logic [4:0] MULT  = 5'b01111;
   localparam logic [4:0] MULTU = 5'b11111;
   localparam logic [4:0] DIV   = 5'b01110;
   localparam logic [4:0] DIVU  = 5'b11110;

   hilo_mdu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
      .op         (op),
      .a          (a),
      .b          (b),
      .mul_result (mul_result),
      .mthi       (mthi),
      .mtlo       (mtlo),
      .wdata      (wdata),
      .flush      (flush),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_annul  (div_annul),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_ready  (div_ready),
      .div_result (div_result),
      .stall      (stall),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      op_valid   = 1'b0;
      op         = 5'b00000;
      a          = '0;
      b          = '0;
      mul_result = '0;
      mthi       = 1'b0;
      mtlo       = 1'b0;
      wdata      = '0;
      flush      = 1'b0;
      div_ready  = 1'b0;
      div_result = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      op_valid = 1'b1;
      op       = DIV;
      #3;
      n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL reset_div_start: got %b want 0", div_start); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
      n_cmp++; if ({div_a, div_b} !== 64'h0) begin n_bad++; $display("FAIL reset_div_ab: got %h want 0", {div_a, div_b}); end
      @(negedge clk);
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      $display("reset: outputs checked while held");
   endtask

   task automatic test_mult();
      @(negedge clk);
      op_valid = 1'b1; op = MULT; a = 32'hFFFFFFFE; b = 32'd3;
      mul_result = 64'hFFFFFFFF_FFFFFFFA;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mult_stall: got %b want 0", stall); end
      @(negedge clk);
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mult_stall_after: got %b want 0", stall); end
      idle_inputs();
      $display("mult: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_divu();
      @(negedge clk);
      op_valid = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
      #1;
      n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL divu_start: got %b want 1", div_start); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL divu_stall_start: got %b want 1", stall); end
      n_cmp++; if (div_signed !== 1'b0) begin n_bad++; $display("FAIL divu_signed: got %b want 0", div_signed); end
      @(negedge clk);
      a = 32'd55; b = 32'd66;
      #1;
      n_cmp++; if (div_a !== 32'd100) begin n_bad++; $display("FAIL divu_div_a: got %0d want 100", div_a); end
      n_cmp++; if (div_b !== 32'd7) begin n_bad++; $display("FAIL divu_div_b: got %0d want 7", div_b); end
      n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL divu_start_busy: got %b want 0", div_start); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL divu_stall_busy: got %b want 1", stall); end
      @(negedge clk);
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divu_hi_hold: got %h want ffffffff", hi); end
      div_ready = 1'b1; div_result = {32'd2, 32'd14};
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL divu_stall_ready: got %b want 1", stall); end
      @(negedge clk);
      div_ready = 1'b0; div_result = '0;
      #1;
      n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi: got %0d want 2", hi); end
      n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo: got %0d want 14", lo); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL divu_stall_done: got %b want 0", stall); end
      n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL divu_restart: got %b want 0", div_start); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL divu_stall_idle: got %b want 0", stall); end
      $display("divu 100/7: hi=%0d lo=%0d", hi, lo);
   endtask

   task automatic test_div_signed();
      @(negedge clk);
      op_valid = 1'b1; op = DIV; a = 32'hFFFFFFF9; b = 32'd2;
      #1;
      n_cmp++; if (div_signed !== 1'b1) begin n_bad++; $display("FAIL div_signed_start: got %b want 1", div_signed); end
      n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL div_start: got %b want 1", div_start); end
      @(negedge clk);
      #1;
      n_cmp++; if (div_signed !== 1'b1) begin n_bad++; $display("FAIL div_signed_busy: got %b want 1", div_signed); end
      div_ready = 1'b1; div_result = {32'hFFFFFFFF, 32'hFFFFFFFD};
      @(negedge clk);
      div_ready = 1'b0; div_result = '0; op_valid = 1'b0;
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      @(negedge clk);
      idle_inputs();
      $display("div -7/2: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_div_flush();
      @(negedge clk);
      op_valid = 1'b1; op = DIV; a = 32'd9; b = 32'd3;
      @(negedge clk);
      #1;
      n_cmp++; if (div_annul !== 1'b0) begin n_bad++; $display("FAIL flush_annul_early: got %b want 0", div_annul); end
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1; div_ready = 1'b1; div_result = {32'd1, 32'd2};
      #1;
      n_cmp++; if (div_annul !== 1'b1) begin n_bad++; $display("FAIL flush_annul: got %b want 1", div_annul); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL flush_hilo: got %h want ffffffff_fffffffd", {hi, lo}); end
      n_cmp++; if (div_annul !== 1'b0) begin n_bad++; $display("FAIL flush_annul_after: got %b want 0", div_annul); end
      op_valid = 1'b1; op = MULT; mul_result = 64'h11112222_33334444;
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== 64'h11112222_33334444) begin n_bad++; $display("FAIL flush_then_idle_mult: got %h want 11112222_33334444", {hi, lo}); end
      idle_inputs();
      $display("div flushed on ready: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_move();
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== 64'h12345678_12345678) begin n_bad++; $display("FAIL move_idle: got %h want 12345678_12345678", {hi, lo}); end
      mthi = 1'b0; mtlo = 1'b0;
      op_valid = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== 64'h12345678_12345678) begin n_bad++; $display("FAIL move_busy: got %h want 12345678_12345678", {hi, lo}); end
      mthi = 1'b0; mtlo = 1'b0;
      div_ready = 1'b1; div_result = {32'd0, 32'd1};
      @(negedge clk);
      div_ready = 1'b0; op_valid = 1'b0;
      n_cmp++; if ({hi, lo} !== 64'h00000000_00000001) begin n_bad++; $display("FAIL move_div_result: got %h want 0_1", {hi, lo}); end
      mthi = 1'b1; wdata = 32'hAAAAAAAA;
      @(negedge clk);
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL move_done_ignored: got %h want 0", hi); end
      mthi = 1'b1; wdata = 32'h77; op_valid = 1'b1; op = MULT; mul_result = {32'd5, 32'd6};
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== {32'd5, 32'd6}) begin n_bad++; $display("FAIL move_mult_priority: got %h want 5_6", {hi, lo}); end
      idle_inputs();
      $display("move-to: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_idle_flush();
      @(negedge clk);
      op_valid = 1'b1; op = MULT; mul_result = {32'd9, 32'd9}; flush = 1'b1; mthi = 1'b1; wdata = 32'h99;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL iflush_mult_stall: got %b want 0", stall); end
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== {32'd5, 32'd6}) begin n_bad++; $display("FAIL iflush_mult: got %h want 5_6", {hi, lo}); end
      mthi = 1'b0; op = DIVU; a = 32'd8; b = 32'd2;
      #1;
      n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL iflush_div_start: got %b want 0", div_start); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL iflush_div_stall: got %b want 0", stall); end
      @(negedge clk);
      idle_inputs();
      div_ready = 1'b1; div_result = {32'd7, 32'd7};
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL iflush_still_idle: got %b want 0", stall); end
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== {32'd5, 32'd6}) begin n_bad++; $display("FAIL idle_ready_ignored: got %h want 5_6", {hi, lo}); end
      idle_inputs();
      $display("idle flush / stray ready: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_div_by_zero();
      @(negedge clk);
      op_valid = 1'b1; op = DIVU; a = 32'h50; b = 32'd0;
      @(negedge clk);
      div_ready = 1'b1; div_result = {32'h50, 32'hFFFFFFFF};
      @(negedge clk);
      div_ready = 1'b0; op_valid = 1'b0;
      n_cmp++; if ({hi, lo} !== 64'h00000050_FFFFFFFF) begin n_bad++; $display("FAIL divzero_hilo: got %h want 00000050_ffffffff", {hi, lo}); end
      n_cmp++; if (div_annul !== 1'b0) begin n_bad++; $display("FAIL divzero_annul: got %b want 0", div_annul); end
      @(negedge clk);
      idle_inputs();
      $display("divu by zero: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      op_valid = 1'b1; op = DIV; a = 32'd3; b = 32'd4;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL areset_hilo: got %h want 0", {hi, lo}); end
      n_cmp++; if ({div_a, div_b} !== 64'h0) begin n_bad++; $display("FAIL areset_div_ab: got %h want 0", {div_a, div_b}); end
      n_cmp++; if ({div_start, div_signed, div_annul, stall} !== 4'b0000) begin n_bad++; $display("FAIL areset_ctrl: got %b want 0000", {div_start, div_signed, div_annul, stall}); end
      @(negedge clk);
      rst = 1'b1;
      op = MULTU; a = 32'd5; b = 32'd6; mul_result = 64'd30;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL areset_multu_stall: got %b want 0", stall); end
      @(negedge clk);
      n_cmp++; if (lo !== 32'd30) begin n_bad++; $display("FAIL areset_multu_lo: got %0d want 30", lo); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL areset_multu_hi: got %0d want 0", hi); end
      idle_inputs();
      $display("async reset mid-divide then multu 5x6: hi=%0d lo=%0d", hi, lo);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_mult();
      test_divu();
      test_div_signed();
      test_div_flush();
      test_move();
      test_idle_flush();
      test_div_by_zero();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hilo_mdu_ctrl.md
HILO_MDU_CTRL -- requirements
Module: hilo_mdu_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 op_valid  in  1  execute-stage instruction valid.
REQ-004 op  in  5  ALU control code: 01111 MULT, 11111 MULTU, 01110 DIV, 11110 DIVU; other codes do not start multiply or divide operations.
REQ-005 a, b  in  32 each  rs, rt operands.
REQ-006 mul_result  in  64  product {hi,lo} from the combinational multiplier, valid in the same cycle.
REQ-007 mthi, mtlo, wdata  in  1/1/32  HI/LO move-to requests and data.
REQ-008 flush  in  1  exception/flush of the execute-stage instruction.
REQ-009 div_start, div_signed, div_annul  out  1 each  divider control.
REQ-010 div_a, div_b  out  32 each  latched divider operands.
REQ-011 div_ready, div_result  in  1/64  divider done pulse and {remainder,quotient}.
REQ-012 stall  out  1  pipeline stall request.
REQ-013 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-014 FSM states: IDLE, DIV_BUSY, DIV_DONE; reset state IDLE.
REQ-015 IDLE, op_valid, op=MULT/MULTU, !flush: {hi,lo} <= mul_result at the edge; stall=0; state stays IDLE.
REQ-016 IDLE, op_valid, op=DIV/DIVU, !flush: div_start=1 for exactly that cycle; div_signed=(op==01110); div_a/div_b <= a/b; stall=1 combinationally; next state DIV_BUSY.
REQ-017 div_a/div_b hold their values through DIV_BUSY, independent of a/b.
REQ-018 DIV_BUSY: stall=1, div_start=0; on div_ready=1: hi<=div_result[63:32], lo<=div_result[31:0]; next state DIV_DONE.
REQ-019 DIV_DONE: stall=0 for exactly one cycle; the still-presented divide op is ignored (no restart); next state IDLE.
REQ-020 flush in DIV_BUSY: div_annul=1 for that cycle; HI/LO not written even if div_ready is 1 in the same cycle; stall=0; next state IDLE.
REQ-021 flush in IDLE suppresses every HI/LO write and div_start in that cycle.
REQ-022 IDLE, !flush: mthi=1 -> hi<=wdata; mtlo=1 -> lo<=wdata; both asserted writes both registers.
REQ-023 A multiply that coincides with mthi/mtlo takes priority and writes mul_result.
REQ-024 mthi/mtlo/MULT in DIV_BUSY or DIV_DONE are ignored.
REQ-025 Divide-by-zero follows the normal divide flow: the divider result is written as-is, and no exception is raised.
REQ-026 div_ready in IDLE or DIV_DONE is ignored.
REQ-027 div_annul=0 outside REQ-020.
REQ-028 No combinational path from div_result to stall.

Reset
REQ-029 rst=0 forces IDLE, hi=lo=0, div_a=div_b=0, and div_start=div_signed=div_annul=stall=0, asynchronously and independent of clk.
REQ-030 Reset during DIV_BUSY abandons the operation with no HI/LO write; the first op after release is accepted normally.

Verification
REQ-031 MULT, a=0xFFFFFFFE, b=3, mul_result=0xFFFFFFFF_FFFFFFFA -> next edge hi=0xFFFFFFFF, lo=0xFFFFFFFA, stall never 1.
REQ-032 DIVU a=100, b=7 -> div_start=1 for 1 cycle and stall=1 until div_ready; divider returns {2,14} -> hi=2, lo=14; stall=0 in DIV_DONE; no second div_start.
REQ-033 DIV a=-7 (0xFFFFFFF9), b=2 -> div_signed=1; result {0xFFFFFFFF,0xFFFFFFFD} -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-034 DIV started, flush asserted on the 3rd busy cycle, coinciding with div_ready -> div_annul=1, hi/lo unchanged, state IDLE next.
REQ-035 mthi=mtlo=1, wdata=0x12345678 in IDLE -> hi=lo=0x12345678; the same request during DIV_BUSY -> no change.
REQ-036 rst=0 mid-divide, between clock edges -> outputs zero immediately; after release, MULTU 5x6 -> lo=30, hi=0.
